unidad_convolucion: RTL and testbench

//  Downstream consumer of ventana_pixeles: loads the NxN mask coefficients from on-chip memory port 2.
//  For every valid pixel window, computes the sum of pixel_k*coef_k with one serial MAC per cycle.

---
 rtl/unidad_convolucion_if.sv | 24 ++
 rtl/unidad_convolucion.sv | 147 ++++++++++++++
 tb/tb_unidad_convolucion.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidad_convolucion_if.sv
// On-chip memory port 2 bus: the convolution unit is the master, the memory is the slave.
interface unidad_convolucion_if #(
    parameter int BITS_MEMORY_DATA     = 32,
    parameter int BITS_ADDR_MEM_ONCHIP = 14
) ();
    logic                            read_mem;
    logic [BITS_ADDR_MEM_ONCHIP-1:0] address_mem;
    logic                            op_complete_mem;
    logic [BITS_MEMORY_DATA-1:0]     data_mem;

    modport master (
        output read_mem,
        output address_mem,
        input  op_complete_mem,
        input  data_mem
    );

    modport slave (
        input  read_mem,
        input  address_mem,
        output op_complete_mem,
        output data_mem
    );
endinterface

// File: rtl/unidad_convolucion.sv
// Loads an NxN signed mask from on-chip memory, then convolves each pixel window with a
// serial MAC and hands out a normalised, saturated 8-bit pixel over valid/accept.
module unidad_convolucion #(
    parameter int BITS_MEMORY_DATA      = 32,
    parameter int BITS_ADDR_MEM_ONCHIP  = 14,
    parameter int BITS_ELEMENTO_MASCARA = 10,
    parameter int SHIFT_NORMALIZACION   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic [BITS_ADDR_MEM_ONCHIP-1:0] direccion_mem_inicio_mascara,
    input  logic [2:0]                      tamano_mascara,
    unidad_convolucion_if.master            mem,
    input  logic                            ventana_valida,
    input  logic [199:0]                    ventana_pixeles,
    output logic                            siguiente_ventana,
    output logic [7:0]                      pixel_resultado,
    output logic                            resultado_valido,
    input  logic                            resultado_aceptado,
    output logic                            ocupado,
    output logic                            error_config
);
    localparam int BITS_PROD = 9 + BITS_ELEMENTO_MASCARA;
    localparam int BITS_ACC  = 24;

    typedef enum logic [2:0] {IDLE, CARGA, ESPERA, MAC, SALIDA} estado_t;

    estado_t                                 estado;
    logic [BITS_ADDR_MEM_ONCHIP-1:0]         dir_inicio;
    logic [4:0]                              n_cuadrado;
    logic [4:0]                              indice;
    logic signed [BITS_ELEMENTO_MASCARA-1:0] coef [25];
    logic [199:0]                            ventana;
    logic signed [BITS_ACC-1:0]              acc;

    logic [7:0]                              sel_bit;
    logic [7:0]                              pixel_actual;
    logic signed [BITS_ELEMENTO_MASCARA-1:0] coef_actual;
    logic signed [BITS_PROD-1:0]             producto;
    logic signed [BITS_ACC-1:0]              escalado;
    logic [7:0]                              saturado;
    logic                                    datos_unused;

    assign datos_unused = ^mem.data_mem[BITS_MEMORY_DATA-1:BITS_ELEMENTO_MASCARA];

    // indice is zero-based: term k of the window (k = 1..N*N) is handled when indice = k-1
    always_comb begin
        sel_bit      = {indice, 3'b000};
        pixel_actual = ventana[sel_bit +: 8];
        coef_actual  = coef[indice];
        producto     = BITS_PROD'($signed({1'b0, pixel_actual})) * BITS_PROD'(coef_actual);
        escalado     = acc >>> SHIFT_NORMALIZACION;
        if (escalado[BITS_ACC-1])
            saturado = '0;
        else if (|escalado[BITS_ACC-2:8])
            saturado = '1;
        else
            saturado = escalado[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado            <= IDLE;
            dir_inicio        <= '0;
            n_cuadrado        <= '0;
            indice            <= '0;
            ventana           <= '0;
            acc               <= '0;
            for (int unsigned k = 0; k < 25; k++)
                coef[k] <= '0;
            mem.read_mem      <= 1'b0;
            mem.address_mem   <= '0;
            siguiente_ventana <= 1'b0;
            pixel_resultado   <= '0;
            resultado_valido  <= 1'b0;
            ocupado           <= 1'b0;
            error_config      <= 1'b0;
        end else begin
            siguiente_ventana <= 1'b0;
            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        if (tamano_mascara == 3'd3 || tamano_mascara == 3'd5) begin
                            error_config    <= 1'b0;
                            dir_inicio      <= direccion_mem_inicio_mascara;
                            n_cuadrado      <= (tamano_mascara == 3'd3) ? 5'd9 : 5'd25;
                            indice          <= '0;
                            for (int unsigned k = 0; k < 25; k++)
                                coef[k] <= '0;
                            mem.read_mem    <= 1'b1;
                            mem.address_mem <= direccion_mem_inicio_mascara;
                            ocupado         <= 1'b1;
                            estado          <= CARGA;
                        end else begin
                            error_config <= 1'b1;
                        end
                    end
                end
                CARGA: begin
                    // one idle cycle between reads; completions seen while idle are ignored
                    if (mem.read_mem) begin
                        if (mem.op_complete_mem) begin
                            coef[indice] <= mem.data_mem[BITS_ELEMENTO_MASCARA-1:0];
                            mem.read_mem <= 1'b0;
                            if (indice == n_cuadrado - 5'd1) begin
                                indice <= '0;
                                estado <= ESPERA;
                            end else begin
                                indice <= indice + 5'd1;
                            end
                        end
                    end else begin
                        mem.read_mem    <= 1'b1;
                        mem.address_mem <= dir_inicio + BITS_ADDR_MEM_ONCHIP'(indice);
                    end
                end
                ESPERA: begin
                    if (ventana_valida) begin
                        ventana           <= ventana_pixeles;
                        siguiente_ventana <= 1'b1;
                        acc               <= '0;
                        indice            <= '0;
                        estado            <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + BITS_ACC'(producto);
                    if (indice == n_cuadrado - 5'd1)
                        estado <= SALIDA;
                    else
                        indice <= indice + 5'd1;
                end
                SALIDA: begin
                    if (!resultado_valido) begin
                        resultado_valido <= 1'b1;
                        pixel_resultado  <= saturado;
                    end else if (resultado_aceptado) begin
                        resultado_valido <= 1'b0;
                        estado           <= ESPERA;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unidad_convolucion.sv
// Directed bench for unidad_convolucion: stalling memory model, hand-computed results.
module tb_unidad_convolucion;
    logic         clk = 1'b0;
    logic         reset;
    logic         iniciar;
    logic [13:0]  direccion_mem_inicio_mascara;
    logic [2:0]   tamano_mascara;
    logic         ventana_valida;
    logic [199:0] ventana_pixeles;
    logic         siguiente_ventana;
    logic [7:0]   pixel_resultado;
    logic         resultado_valido;
    logic         resultado_aceptado;
    logic         ocupado;
    logic         error_config;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_img [25];
    int          base_actual = 0;
    int          lecturas = 0;
    int          read_alto = 0;
    int          stall_max = 0;
    logic        pendiente = 1'b0;
    int          espera = 0;
    logic [13:0] dir_pend = '0;

    always #5 clk = ~clk;

    unidad_convolucion_if #(.BITS_MEMORY_DATA(32), .BITS_ADDR_MEM_ONCHIP(14)) mem ();

    unidad_convolucion #(
        .BITS_MEMORY_DATA(32),
        .BITS_ADDR_MEM_ONCHIP(14),
        .BITS_ELEMENTO_MASCARA(10),
        .SHIFT_NORMALIZACION(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iniciar(iniciar),
        .direccion_mem_inicio_mascara(direccion_mem_inicio_mascara),
        .tamano_mascara(tamano_mascara),
        .mem(mem),
        .ventana_valida(ventana_valida),
        .ventana_pixeles(ventana_pixeles),
        .siguiente_ventana(siguiente_ventana),
        .pixel_resultado(pixel_resultado),
        .resultado_valido(resultado_valido),
        .resultado_aceptado(resultado_aceptado),
        .ocupado(ocupado),
        .error_config(error_config)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory slave: random completion delay, address must hold while a read is pending.
    // Spurious completions are injected while no read is requested.
    initial begin
        int off;
        mem.op_complete_mem = 1'b0;
        mem.data_mem        = '0;
        forever begin
            @(negedge clk);
            mem.op_complete_mem = 1'b0;
            mem.data_mem        = $urandom();
            if (mem.read_mem === 1'b1) begin
                read_alto++;
                if (!pendiente) begin
                    pendiente = 1'b1;
                    espera    = $urandom_range(stall_max, 0);
                    dir_pend  = mem.address_mem;
                    chk("dir_lectura", 32'(mem.address_mem), 32'(base_actual + lecturas));
                end else begin
                    chk("dir_estable", 32'(mem.address_mem), 32'(dir_pend));
                end
                if (espera == 0) begin
                    off = int'(mem.address_mem) - base_actual;
                    mem.data_mem        = (off >= 0 && off < 25) ? mem_img[off] : 32'h0;
                    mem.op_complete_mem = 1'b1;
                    pendiente           = 1'b0;
                    lecturas++;
                end else begin
                    espera--;
                end
            end else begin
                pendiente = 1'b0;
                if (stall_max > 0)
                    mem.op_complete_mem = 1'($urandom_range(1, 0));
            end
        end
    end

    task automatic chk_reposo(input string tag);
        chk({tag, "_read_mem"}, 32'(mem.read_mem), 0);
        chk({tag, "_address_mem"}, 32'(mem.address_mem), 0);
        chk({tag, "_siguiente"}, 32'(siguiente_ventana), 0);
        chk({tag, "_pixel"}, 32'(pixel_resultado), 0);
        chk({tag, "_valido"}, 32'(resultado_valido), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
        chk({tag, "_error"}, 32'(error_config), 0);
    endtask

    task automatic llenar_mascara(input logic [9:0] todos, input int k_esp, input logic [9:0] v_esp);
        logic [31:0] r;
        for (int k = 0; k < 25; k++) begin
            r = $urandom();
            mem_img[k] = {r[31:10], (k == k_esp) ? v_esp : todos};
        end
    endtask

    task automatic cargar(input string tag, input int base, input logic [2:0] n);
        int nn;
        int t;
        nn = (n == 3'd3) ? 9 : 25;
        base_actual = base;
        lecturas    = 0;
        @(negedge clk);
        direccion_mem_inicio_mascara = 14'(base);
        tamano_mascara = n;
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        t = 0;
        while (lecturas < nn && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_n_lecturas"}, 32'(lecturas), 32'(nn));
        chk({tag, "_read_mem_fin"}, 32'(mem.read_mem), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 1);
        chk({tag, "_error_limpio"}, 32'(error_config), 0);
    endtask

    task automatic ventana(input string tag, input logic [199:0] pix, input logic [7:0] esperado,
                           input int nn, input int retener, input bit pre_acepta);
        int t;
        int ciclos;
        int extra;
        int anomal;
        @(negedge clk);
        ventana_pixeles = pix;
        ventana_valida  = 1'b1;
        t = 0;
        while (!siguiente_ventana && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_captura"}, 32'(siguiente_ventana), 1);
        if (retener == 0) ventana_valida = 1'b0;
        if (pre_acepta) resultado_aceptado = 1'b1;
        ciclos = 0;
        extra  = 0;
        while (!resultado_valido && ciclos < 100) begin
            @(negedge clk);
            ciclos++;
            if (siguiente_ventana) extra++;
        end
        chk({tag, "_latencia"}, 32'(ciclos), 32'(nn + 1));
        chk({tag, "_pixel"}, 32'(pixel_resultado), 32'(esperado));
        anomal = 0;
        repeat (retener) begin
            @(negedge clk);
            if (siguiente_ventana) extra++;
            if (!resultado_valido || pixel_resultado !== esperado) anomal++;
        end
        if (retener > 0) chk({tag, "_retenido"}, 32'(anomal), 0);
        chk({tag, "_sin_captura_extra"}, 32'(extra), 0);
        resultado_aceptado = 1'b1;
        @(negedge clk);
        resultado_aceptado = 1'b0;
        ventana_valida     = 1'b0;
        chk({tag, "_valido_baja"}, 32'(resultado_valido), 0);
    endtask

    task automatic reiniciar;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [199:0] pix;
        int r0;
        int t;
        reset = 1'b1;
        iniciar = 1'b0;
        direccion_mem_inicio_mascara = '0;
        tamano_mascara = '0;
        ventana_valida = 1'b0;
        ventana_pixeles = '0;
        resultado_aceptado = 1'b0;
        repeat (3) @(negedge clk);
        chk_reposo("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reposo("post_reset");

        // illegal mask size
        tamano_mascara = 3'd4;
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        repeat (5) @(negedge clk);
        chk("n4_error", 32'(error_config), 1);
        chk("n4_ocupado", 32'(ocupado), 0);
        chk("n4_sin_lecturas", 32'(read_alto), 0);

        // N=3, all coefficients 16, stalling memory
        stall_max = 5;
        llenar_mascara(10'd16, -1, 10'd0);
        cargar("n3_c16", 100, 3'd3);

        // iniciar outside IDLE must not start another load
        r0 = read_alto;
        tamano_mascara = 3'd5;
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        repeat (5) @(negedge clk);
        chk("iniciar_ignorado", 32'(read_alto - r0), 0);

        // 16*(1+..+9)=720 >>> 4 = 45
        for (int k = 1; k <= 25; k++) pix[8*k-1 -: 8] = (k <= 9) ? 8'(k) : 8'($urandom());
        ventana("w_1a9", pix, 8'd45, 9, 0, 1'b0);
        // 16*90=1440 >>> 4 = 90, with 20 cycles of backpressure
        for (int k = 1; k <= 25; k++) pix[8*k-1 -: 8] = (k <= 9) ? 8'd10 : 8'($urandom());
        ventana("w_bp", pix, 8'd90, 9, 20, 1'b0);
        // 16*9*255=36720 >>> 4 = 2295 -> 255, accepted on first valid cycle
        pix = '1;
        ventana("w_sat_alto", pix, 8'd255, 9, 0, 1'b1);

        // coef -1: -2295 >>> 4 = -144 -> 0
        reiniciar();
        llenar_mascara(10'h3FF, -1, 10'd0);
        cargar("n3_cm1", 3000, 3'd3);
        pix = '1;
        ventana("w_sat_bajo", pix, 8'd0, 9, 0, 1'b0);

        // coef 2: 4590 >>> 4 = 286 -> 255; 2*45=90 >>> 4 = 5
        reiniciar();
        stall_max = 0;
        llenar_mascara(10'd2, -1, 10'd0);
        cargar("n3_c2", 5, 3'd3);
        pix = '1;
        ventana("w_c2_sat", pix, 8'd255, 9, 0, 1'b0);
        for (int k = 1; k <= 25; k++) pix[8*k-1 -: 8] = (k <= 9) ? 8'(k) : 8'hFF;
        ventana("w_c2_trunc", pix, 8'd5, 9, 0, 1'b0);

        // N=5, only coef_13 = 16: result equals pixel_13
        reiniciar();
        stall_max = 3;
        llenar_mascara(10'd0, 12, 10'd16);
        cargar("n5", 200, 3'd5);
        for (int k = 1; k <= 25; k++) pix[8*k-1 -: 8] = (k == 13) ? 8'd200 : 8'($urandom());
        ventana("w5_200", pix, 8'd200, 25, 0, 1'b0);
        for (int k = 1; k <= 25; k++) pix[8*k-1 -: 8] = (k == 13) ? 8'd77 : 8'($urandom());
        ventana("w5_77", pix, 8'd77, 25, 0, 1'b1);

        // asynchronous reset in the middle of a load
        reiniciar();
        stall_max = 5;
        llenar_mascara(10'd1, -1, 10'd0);
        base_actual = 40;
        lecturas    = 0;
        @(negedge clk);
        direccion_mem_inicio_mascara = 14'd40;
        tamano_mascara = 3'd5;
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        t = 0;
        while (lecturas < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("carga_activa", 32'(ocupado), 1);
        #2 reset = 1'b1;
        #1 chk_reposo("reset_async");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sin_lecturas", 32'(mem.read_mem), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
